// File: rtl/apmu_ibex_pkg.sv
// apmu_ibex_pkg: shared types for the APMU
// multdiv issue wrapper and its slow unit.
package apmu_ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef enum logic [1:0] {
    MDI_IDLE,
    MDI_BUSY,
    MDI_RESP
  } md_issue_fsm_e;

  localparam int ImdW = 34;

  typedef struct packed {
    md_op_e      op;
    logic [1:0]  signed_mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        dit;
  } md_req_t;

  function automatic logic is_mul_op(md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/apmu_ibex_multdiv_issue_if.sv
// apmu_ibex_multdiv_issue_if: request/response
// handshake bundle of the multdiv issue wrapper.
interface apmu_ibex_multdiv_issue_if
  import apmu_ibex_pkg::*;
#(
  parameter int TagW = 4,
  parameter int CycW = 8
) ();

  logic            req_valid;
  logic            req_ready;
  md_op_e          req_operator;
  logic [1:0]      req_signed_mode;
  logic [31:0]     req_op_a;
  logic [31:0]     req_op_b;
  logic [TagW-1:0] req_tag;
  logic            req_dit;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_result;
  logic [TagW-1:0] rsp_tag;
  logic [CycW-1:0] rsp_cycles;

  modport master (
    output req_valid,
    output req_operator,
    output req_signed_mode,
    output req_op_a,
    output req_op_b,
    output req_tag,
    output req_dit,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_result,
    input  rsp_tag,
    input  rsp_cycles
  );

  modport slave (
    input  req_valid,
    input  req_operator,
    input  req_signed_mode,
    input  req_op_a,
    input  req_op_b,
    input  req_tag,
    input  req_dit,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_result,
    output rsp_tag,
    output rsp_cycles
  );

endinterface

// File: rtl/apmu_ibex_md_imd_reg.sv
// apmu_ibex_md_imd_reg: the two 34-bit intermediate
// registers owned on behalf of the slow multdiv unit.
module apmu_ibex_md_imd_reg
  import apmu_ibex_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      we,
  input  logic [ImdW-1:0] d [2],
  output logic [ImdW-1:0] q [2]
);

  // Per-entry load, only while the owner is busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q[0] <= '0;
      q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (en && we[i]) begin
          q[i] <= d[i];
        end
      end
    end
  end

endmodule

// File: rtl/apmu_ibex_multdiv_issue.sv
// apmu_ibex_multdiv_issue: one-deep issue/response
// wrapper with cycle profiling for the slow multdiv.
module apmu_ibex_multdiv_issue
  import apmu_ibex_pkg::*;
#(
  parameter int TagW = 4,
  parameter int CycW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,

  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  md_op_e          req_operator_i,
  input  logic [1:0]      req_signed_mode_i,
  input  logic [31:0]     req_op_a_i,
  input  logic [31:0]     req_op_b_i,
  input  logic [TagW-1:0] req_tag_i,
  input  logic            req_dit_i,

  output logic            mult_en_o,
  output logic            div_en_o,
  output logic            mult_sel_o,
  output logic            div_sel_o,
  output md_op_e          operator_o,
  output logic [1:0]      signed_mode_o,
  output logic [31:0]     op_a_o,
  output logic [31:0]     op_b_o,
  output logic            data_ind_timing_o,

  output logic [ImdW-1:0] imd_val_q_o [2],
  input  logic [ImdW-1:0] imd_val_d_i [2],
  input  logic [1:0]      imd_val_we_i,

  output logic            multdiv_ready_id_o,
  input  logic [31:0]     multdiv_result_i,
  input  logic            multdiv_valid_i,

  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [31:0]     rsp_result_o,
  output logic [TagW-1:0] rsp_tag_o,
  output logic [CycW-1:0] rsp_cycles_o
);

  md_issue_fsm_e   state_q;
  md_issue_fsm_e   state_d;
  md_req_t         req_q;
  logic [TagW-1:0] tag_q;
  logic [CycW-1:0] cyc_q;
  logic [CycW-1:0] cyc_inc;
  logic [31:0]     res_q;

  logic ready;
  logic busy;
  logic rsp_valid;
  logic load;
  logic capture;
  logic is_mul;

  // Next state and handshake strobes; reset forces all idle
  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    load      = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      MDI_IDLE: begin
        ready = 1'b1;
        if (req_valid_i) begin
          load    = 1'b1;
          state_d = MDI_BUSY;
        end
      end
      MDI_BUSY: begin
        busy = 1'b1;
        if (multdiv_valid_i) begin
          capture = 1'b1;
          state_d = MDI_RESP;
        end
      end
      MDI_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready_i) begin
          ready   = 1'b1;
          state_d = MDI_IDLE;
          if (req_valid_i) begin
            load    = 1'b1;
            state_d = MDI_BUSY;
          end
        end
      end
      default: state_d = MDI_IDLE;
    endcase
    if (!rst_ni) begin
      ready     = 1'b0;
      busy      = 1'b0;
      rsp_valid = 1'b0;
      load      = 1'b0;
      capture   = 1'b0;
    end
  end

  assign cyc_inc = (cyc_q == '1) ? cyc_q
                 : cyc_q + CycW'(1);

  // State, latched request, cycle counter, result
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= MDI_IDLE;
      req_q   <= '0;
      tag_q   <= '0;
      cyc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        req_q.op          <= req_operator_i;
        req_q.signed_mode <= req_signed_mode_i;
        req_q.op_a        <= req_op_a_i;
        req_q.op_b        <= req_op_b_i;
        req_q.dit         <= req_dit_i;
        tag_q             <= req_tag_i;
        cyc_q             <= '0;
      end else if (busy) begin
        cyc_q <= cyc_inc;
      end
      if (capture) begin
        res_q <= multdiv_result_i;
      end
    end
  end

  assign is_mul = is_mul_op(req_q.op);

  assign req_ready_o        = ready;
  assign mult_en_o          = busy & is_mul;
  assign mult_sel_o         = busy & is_mul;
  assign div_en_o           = busy & ~is_mul;
  assign div_sel_o          = busy & ~is_mul;
  assign multdiv_ready_id_o = busy;

  assign operator_o        = req_q.op;
  assign signed_mode_o     = req_q.signed_mode;
  assign op_a_o            = req_q.op_a;
  assign op_b_o            = req_q.op_b;
  assign data_ind_timing_o = req_q.dit;

  assign rsp_valid_o  = rsp_valid;
  assign rsp_result_o = res_q;
  assign rsp_tag_o    = tag_q;
  assign rsp_cycles_o = cyc_q;

  apmu_ibex_md_imd_reg u_imd (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (busy),
    .we    (imd_val_we_i),
    .d     (imd_val_d_i),
    .q     (imd_val_q_o)
  );

  state_legal_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    state_q inside {MDI_IDLE, MDI_BUSY, MDI_RESP}
  );

endmodule

// File: tb/tb_apmu_ibex_multdiv_issue.sv
// tb_apmu_ibex_multdiv_issue: scoreboard bench with a
// behavioural slow-unit stand-in driving result timing.
module tb_apmu_ibex_multdiv_issue;
  import apmu_ibex_pkg::*;

  localparam int TagW = 4;
  localparam int CycW = 8;

  typedef struct packed {
    logic [31:0]     res;
    logic [TagW-1:0] tag;
    logic [CycW-1:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apmu_ibex_multdiv_issue_if #(
    .TagW(TagW), .CycW(CycW)
  ) bus ();

  logic        mult_en, div_en, mult_sel, div_sel;
  md_op_e      oper;
  logic [1:0]  smode;
  logic [31:0] op_a, op_b;
  logic        dit;
  logic [33:0] imd_q [2];
  logic [33:0] imd_d [2];
  logic [1:0]  imd_we;
  logic        md_ready;
  logic [31:0] md_result;
  logic        md_valid;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cur_len = 0;
  logic [31:0] cur_res = '0;

  apmu_ibex_multdiv_issue #(
    .TagW(TagW), .CycW(CycW)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req_valid_i        (bus.req_valid),
    .req_ready_o        (bus.req_ready),
    .req_operator_i     (bus.req_operator),
    .req_signed_mode_i  (bus.req_signed_mode),
    .req_op_a_i         (bus.req_op_a),
    .req_op_b_i         (bus.req_op_b),
    .req_tag_i          (bus.req_tag),
    .req_dit_i          (bus.req_dit),
    .mult_en_o          (mult_en),
    .div_en_o           (div_en),
    .mult_sel_o         (mult_sel),
    .div_sel_o          (div_sel),
    .operator_o         (oper),
    .signed_mode_o      (smode),
    .op_a_o             (op_a),
    .op_b_o             (op_b),
    .data_ind_timing_o  (dit),
    .imd_val_q_o        (imd_q),
    .imd_val_d_i        (imd_d),
    .imd_val_we_i       (imd_we),
    .multdiv_ready_id_o (md_ready),
    .multdiv_result_i   (md_result),
    .multdiv_valid_i    (md_valid),
    .rsp_valid_o        (bus.rsp_valid),
    .rsp_ready_i        (bus.rsp_ready),
    .rsp_result_o       (bus.rsp_result),
    .rsp_tag_o          (bus.rsp_tag),
    .rsp_cycles_o       (bus.rsp_cycles)
  );

  function automatic void chk(string name,
                              logic [63:0] act,
                              logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, req);
    end
  endfunction

  // Slow-unit stand-in: result after cur_len busy
  // cycles; imd written on busy cycle 1, junk otherwise
  initial begin
    int cnt;
    cnt       = 0;
    md_valid  = 1'b0;
    md_result = '0;
    imd_we    = 2'b11;
    imd_d[0]  = 34'h3_1111_1111;
    imd_d[1]  = 34'h3_2222_2222;
    forever begin
      @(posedge clk);
      #1;
      md_valid = 1'b0;
      imd_we   = 2'b11;
      imd_d[0] = 34'h3_1111_1111;
      imd_d[1] = 34'h3_2222_2222;
      if (mult_en || div_en) begin
        cnt++;
        if (cnt == 1) begin
          imd_d[0] = 34'h2_5A5A_5A5A;
          imd_d[1] = 34'h1_A5A5_A5A5;
        end else begin
          imd_we = 2'b00;
        end
        if (cnt == cur_len) begin
          md_valid  = 1'b1;
          md_result = cur_res;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pop and compare on every response handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual=%h required=none",
                   bus.rsp_result);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_result", bus.rsp_result, e.res);
          chk("rsp_tag", bus.rsp_tag, e.tag);
          chk("rsp_cycles", bus.rsp_cycles, e.cyc);
        end
      end
    end
  end

  task automatic issue(md_op_e op, logic [1:0] sm,
                       logic [31:0] a, logic [31:0] b,
                       logic [TagW-1:0] tag, logic d,
                       int len, logic [31:0] res,
                       bit raise_rsp);
    bit   acc;
    int   t;
    exp_t e;
    acc = 1'b0;
    t   = 0;
    @(negedge clk);
    bus.req_valid       = 1'b1;
    bus.req_operator    = op;
    bus.req_signed_mode = sm;
    bus.req_op_a        = a;
    bus.req_op_b        = b;
    bus.req_tag         = tag;
    bus.req_dit         = d;
    if (raise_rsp) bus.rsp_ready = 1'b1;
    cur_len = len;
    cur_res = res;
    e.res = res;
    e.tag = tag;
    e.cyc = CycW'(len);
    exp_q.push_back(e);
    while (!acc && t < 300) begin
      #1;
      acc = bus.req_ready;
      @(negedge clk);
      t++;
    end
    bus.req_valid = 1'b0;
    bus.req_op_a  = 32'hDEAD_0000;
    bus.req_op_b  = 32'h0000_BEEF;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
    chk("op_a_latched", op_a, a);
    chk("op_b_latched", op_b, b);
    chk("operator", oper, op);
    chk("signed_mode", smode, sm);
    chk("dit", dit, d);
    chk("md_ready_busy", md_ready, 1'b1);
    chk("mult_en", {mult_en, mult_sel},
        {2{(op == MD_OP_MULL) || (op == MD_OP_MULH)}});
    chk("div_en", {div_en, div_sel},
        {2{(op == MD_OP_DIV) || (op == MD_OP_REM)}});
  endtask

  task automatic wait_drain(string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain actual=pending required=empty",
               name);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=done");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    bus.req_valid       = 1'b0;
    bus.req_operator    = MD_OP_MULL;
    bus.req_signed_mode = 2'b00;
    bus.req_op_a        = '0;
    bus.req_op_b        = '0;
    bus.req_tag         = '0;
    bus.req_dit         = 1'b0;
    bus.rsp_ready       = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_en", {mult_en, div_en, md_ready}, 3'b000);
    chk("rst_op_a", op_a, 32'h0);
    chk("rst_cycles", bus.rsp_cycles, 8'h0);
    chk("rst_imd0", imd_q[0], 34'h0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_req_ready", bus.req_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("idle_imd0_hold", imd_q[0], 34'h0);
    chk("idle_imd1_hold", imd_q[1], 34'h0);

    issue(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 4'h1,
          1'b0, 33, 32'h0000_002A, 1'b0);
    wait_drain("mull_7x6");
    chk("imd0_written", imd_q[0], 34'h2_5A5A_5A5A);
    chk("imd1_written", imd_q[1], 34'h1_A5A5_A5A5);

    issue(MD_OP_MULL, 2'b00, 32'h1234, 32'd1, 4'h2,
          1'b0, 2, 32'h0000_1234, 1'b0);
    wait_drain("mull_b1");
    issue(MD_OP_MULL, 2'b00, 32'h1234, 32'd1, 4'h3,
          1'b1, 33, 32'h0000_1234, 1'b0);
    wait_drain("mull_b1_dit");

    issue(MD_OP_DIV, 2'b11, 32'hFFFF_FF9C, 32'd7, 4'h4,
          1'b0, 37, 32'hFFFF_FFF2, 1'b0);
    wait_drain("div_signed");
    issue(MD_OP_REM, 2'b11, 32'hFFFF_FF9C, 32'd7, 4'h5,
          1'b0, 37, 32'hFFFF_FFFE, 1'b0);
    wait_drain("rem_signed");

    issue(MD_OP_DIV, 2'b00, 32'h55, 32'd0, 4'h6,
          1'b0, 2, 32'hFFFF_FFFF, 1'b0);
    wait_drain("div_by0");
    issue(MD_OP_REM, 2'b00, 32'h55, 32'd0, 4'h7,
          1'b0, 2, 32'h0000_0055, 1'b0);
    wait_drain("rem_by0");

    bus.rsp_ready = 1'b0;
    issue(MD_OP_MULL, 2'b00, 32'd3, 32'd5, 4'h9,
          1'b0, 33, 32'd15, 1'b0);
    t = 0;
    while (!bus.rsp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("hold_rsp_valid", bus.rsp_valid, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_op_a  = 32'h77;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("hold_result", bus.rsp_result, 32'd15);
      chk("hold_tag", bus.rsp_tag, 4'h9);
      chk("hold_req_ready", bus.req_ready, 1'b0);
    end
    chk("hold_op_a_ignored", op_a, 32'd3);
    bus.req_valid = 1'b0;
    issue(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'd2, 4'hA,
          1'b0, 33, 32'hFFFF_FFFF, 1'b1);
    wait_drain("b2b_mulh");

    issue(MD_OP_DIV, 2'b00, 32'd500, 32'd3, 4'h5,
          1'b0, 37, 32'd166, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    exp_q.delete();
    chk("midrst_req_ready", bus.req_ready, 1'b0);
    chk("midrst_en",
        {mult_en, div_en, mult_sel, div_sel, md_ready},
        5'b0);
    chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("midrst_ops", {op_a, op_b}, 64'h0);
    chk("midrst_mode", {oper, smode, dit}, 5'b0);
    chk("midrst_payload",
        {bus.rsp_result, bus.rsp_tag, bus.rsp_cycles},
        44'h0);
    chk("midrst_imd0", imd_q[0], 34'h0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_after_ready", bus.req_ready, 1'b1);

    issue(MD_OP_MULH, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          4'hF, 1'b0, 33, 32'h0000_0000, 1'b0);
    wait_drain("mulh_m1xm1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apmu_ibex_multdiv_issue.md
# apmu_ibex_multdiv_issue

Issue/response wrapper directly upstream of `apmu_ibex_multdiv_slow`. It accepts one multiply/divide request at a time over a valid/ready handshake and latches the operands. It drives the slow unit's enable/select/operand inputs and owns the two intermediate-value registers. It captures the result into a one-entry response buffer tagged with the requester ID and the operation's cycle count, which the APMU uses for per-op latency profiling.

## Interface
Parameters:
- `TagW`, 4: width of the request/response tag.
- `CycW`, 8: width of the saturating per-op cycle counter.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted this cycle when high together with `req_valid_i`.
- `req_operator_i` in `apmu_ibex_pkg::md_op_e`: operation.
- `req_signed_mode_i` in 2: bit0 = A signed, bit1 = B signed.
- `req_op_a_i`, `req_op_b_i` in 32: operands.
- `req_tag_i` in `TagW`: requester ID.
- `req_dit_i` in 1: data-independent timing for this op.
- `mult_en_o`, `div_en_o`, `mult_sel_o`, `div_sel_o` out 1: slow-unit control.
- `operator_o` out `md_op_e`; `signed_mode_o` out 2; `op_a_o`, `op_b_o` out 32; `data_ind_timing_o` out 1: latched request fields.
- `imd_val_q_o[2]` out 34 each: intermediate registers.
- `imd_val_d_i[2]` in 34 each; `imd_val_we_i` in 2: intermediate register write data and enables.
- `multdiv_ready_id_o` out 1: result consumption strobe to the slow unit.
- `multdiv_result_i` in 32; `multdiv_valid_i` in 1: slow-unit result.
- `rsp_valid_o` out 1; `rsp_ready_i` in 1: response handshake.
- `rsp_result_o` out 32; `rsp_tag_o` out `TagW`; `rsp_cycles_o` out `CycW`: response payload.

## Operation
- FSM `IDLE`, `BUSY`, `RESP`. All regs reset to 0, FSM to `IDLE`.
- `IDLE`: `req_ready_o`=1. On `req_valid_i`, latch operator, signed mode, A, B, tag and DIT, clear the cycle counter, and go to `BUSY`.
- `BUSY`: `mult_en_o`=`mult_sel_o`=1 for MULL/MULH. `div_en_o`=`div_sel_o`=1 for DIV/REM. `multdiv_ready_id_o`=1, so the slow unit never holds. The cycle counter increments each `BUSY` cycle and saturates at 2^CycW-1. On `multdiv_valid_i`, capture `multdiv_result_i` into the response register, include the final cycle in the count, and go to `RESP`.
- `RESP`: `rsp_valid_o`=1 and the payload is stable. On `rsp_ready_i`, go to `IDLE`. If `req_valid_i` is also high in that cycle, `req_ready_o`=1, the new request is latched, and the FSM goes directly to `BUSY` (back-to-back).
- All slow-unit enables and selects are 0 outside `BUSY`. The operand outputs keep their latched values at all times.
- Intermediate registers: `imd_val_q[i]` loads `imd_val_d_i[i]` when `imd_val_we_i[i]` and the FSM is in `BUSY`. Otherwise they hold.
- `req_*` inputs are ignored when `req_ready_o`=0.
- `multdiv_valid_i` outside `BUSY` is ignored.
- Reset asserted mid-operation returns every register to 0 and the FSM to `IDLE`. The slow unit's own state is reset by the same `rst_ni`.

## Timing
- Request accepted at cycle N. The slow unit sees its idle state at N+1.
- `multdiv_valid_i` at cycle M gives `rsp_valid_o` at M+1, with `rsp_cycles_o` = M-N.
- `BUSY` lengths with DIT=0:
  - MULH: 33.
  - MULL with B in {0,1}: 2.
  - DIV/REM: 37.
  - DIV/REM with B=0: 2.
- With DIT=1, MULL takes 33 and DIV/REM with B=0 take 37.
- Throughput: one op per `BUSY` length + 1 cycle when `rsp_ready_i` is held high.
- Reset values: `req_ready_o` is 0 during reset and 1 in the first cycle after reset. All other outputs are 0 during and immediately after reset.

## Structure
- `apmu_ibex_pkg`: add `md_issue_fsm_e {MDI_IDLE, MDI_BUSY, MDI_RESP}`. Reuse the existing `md_op_e`.
- One sub-module: `apmu_ibex_md_imd_reg`, holding the 2×34-bit intermediate registers with per-entry write enable and an `en` qualifier.
- Assert that the FSM state is always one of the three legal states.

## Test plan
- MULL A=7, B=6, DIT=0, `rsp_ready_i`=1 → result 0x0000002A after 33 `BUSY` cycles; `rsp_cycles_o`=33; tag echoed.
- MULL A=0x1234, B=1, DIT=0 → result 0x00001234; `rsp_cycles_o`=2. Same with DIT=1 → `rsp_cycles_o`=33.
- DIV signed A=-100, B=7 → result 0xFFFFFFF2 (-14); `rsp_cycles_o`=37. REM same operands → 0xFFFFFFFE (-2).
- DIV B=0, DIT=0 → result 0xFFFFFFFF, `rsp_cycles_o`=2. REM B=0 → result A.
- Hold `rsp_ready_i`=0 for 10 cycles in `RESP` → payload stable and `req_ready_o`=0. Then raise `rsp_ready_i` together with `req_valid_i` → new request accepted in the same cycle.
- Assert `rst_ni`=0 mid-DIV (cycle 15) → all outputs return to 0 on the next edge. A fresh MULH 0xFFFFFFFF×0xFFFFFFFF signed → 0x00000000.
